// File: rtl/fibergyro_frame_rx.sv
// Receive-side decoder for the fiber-optic gyro RS422 link: drains CoreUART bytes via OEN,
// syncs on HEADER, assembles the 8-byte frame, checks the XOR sum and publishes rate/temp/status.
module fibergyro_frame_rx #(
  parameter logic [7:0]  HEADER      = 8'hDD,
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               ENABLE,
  input  logic               RXrd,
  input  logic [7:0]         RX,
  output logic               OEN,
  output logic signed [23:0] RATE,
  output logic [15:0]        TEMP,
  output logic [7:0]         STATUS,
  output logic               FRAME_VALID,
  output logic               CHK_ERR,
  output logic               TMO_ERR,
  output logic [15:0]        FRAME_CNT,
  output logic [7:0]         ERR_CNT
);

  typedef enum logic [1:0] {F_IDLE, F_RD, F_HOLD} fetch_t;
  typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} frame_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  fetch_t fetch_st, fetch_nxt;
  frame_t st, st_nxt;

  logic [7:0]  rx_byte_p1;
  logic        vld_p1;
  logic [47:0] pay_p2;
  logic [7:0]  chk_p2, chk_nxt;
  logic [2:0]  idx, idx_nxt;
  logic [15:0] gap_cnt;
  logic        shift, good, bad, tmo;

  // Stage 0: byte fetch handshake (one OEN cycle, then one holdoff cycle)
  always_ff @(posedge CLK) begin
    if (RESET) fetch_st <= F_IDLE;
    else       fetch_st <= fetch_nxt;
  end

  always_comb begin
    fetch_nxt = fetch_st;
    OEN       = 1'b1;
    case (fetch_st)
      F_IDLE: if (RXrd) fetch_nxt = F_RD;
      F_RD: begin
        OEN       = 1'b0;
        fetch_nxt = F_HOLD;
      end
      F_HOLD:  fetch_nxt = F_IDLE;
      default: fetch_nxt = F_IDLE;
    endcase
  end

  // Stage 1: byte captured at the end of the OEN cycle
  always_ff @(posedge CLK) begin
    if (RESET) vld_p1 <= 1'b0;
    else       vld_p1 <= (fetch_st == F_RD);
  end

  always_ff @(posedge CLK) begin
    if (fetch_st == F_RD) rx_byte_p1 <= RX;
  end

  // Stage 2: frame assembly, checksum and timeout
  always_comb begin
    st_nxt  = st;
    idx_nxt = idx;
    chk_nxt = chk_p2;
    shift   = 1'b0;
    good    = 1'b0;
    bad     = 1'b0;
    tmo     = 1'b0;
    if (!ENABLE) begin
      st_nxt = HUNT;
    end else if (vld_p1) begin
      case (st)
        HUNT: begin
          if (rx_byte_p1 == HEADER) begin
            st_nxt  = PAYLOAD;
            idx_nxt = 3'd0;
            chk_nxt = 8'h00;
          end
        end
        PAYLOAD: begin
          shift   = 1'b1;
          chk_nxt = chk_p2 ^ rx_byte_p1;
          idx_nxt = idx + 3'd1;
          if (idx == 3'd5) st_nxt = CHECK;
        end
        CHECK: begin
          good   = (rx_byte_p1 == chk_p2);
          bad    = (rx_byte_p1 != chk_p2);
          st_nxt = HUNT;
        end
        default: st_nxt = HUNT;
      endcase
    end else if ((st != HUNT) && (gap_cnt == TIMEOUT_CYC)) begin
      tmo    = 1'b1;
      st_nxt = HUNT;
    end
  end

  always_ff @(posedge CLK) begin
    chk_p2 <= chk_nxt;
    if (shift) pay_p2 <= {pay_p2[39:0], rx_byte_p1};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      st          <= HUNT;
      idx         <= 3'd0;
      gap_cnt     <= 16'd0;
      FRAME_VALID <= 1'b0;
      CHK_ERR     <= 1'b0;
      TMO_ERR     <= 1'b0;
      FRAME_CNT   <= 16'd0;
      ERR_CNT     <= 8'd0;
      RATE        <= '0;
      TEMP        <= 16'd0;
      STATUS      <= 8'd0;
    end else begin
      st          <= st_nxt;
      idx         <= idx_nxt;
      FRAME_VALID <= good;
      CHK_ERR     <= bad;
      TMO_ERR     <= tmo;
      if (vld_p1 || st == HUNT)        gap_cnt <= 16'd0;
      else if (gap_cnt != TIMEOUT_CYC) gap_cnt <= gap_cnt + 16'd1;
      if (good) begin
        RATE      <= signed'(pay_p2[47:24]);
        TEMP      <= pay_p2[23:8];
        STATUS    <= pay_p2[7:0];
        FRAME_CNT <= FRAME_CNT + 16'd1;
      end
      if (bad || tmo) ERR_CNT <= sat_inc8(ERR_CNT);
    end
  end

endmodule

// File: tb/tb_fibergyro_frame_rx.sv
// Directed bench for fibergyro_frame_rx: UART-side byte feeder, pulse monitors and assertions.
module tb_fibergyro_frame_rx;
  localparam logic [15:0] TMO = 16'd40;

  logic               CLK, RESET, ENABLE, RXrd;
  logic [7:0]         RX;
  logic               OEN, FRAME_VALID, CHK_ERR, TMO_ERR;
  logic signed [23:0] RATE;
  logic [15:0]        TEMP, FRAME_CNT;
  logic [7:0]         STATUS, ERR_CNT;

  int total = 0;
  int bad = 0;
  int oen_cnt = 0, fv_cnt = 0, ce_cnt = 0, te_cnt = 0;
  int hdr_lat = 0;
  int oen0, fv0, ce0, te0;
  logic [11:0] oen_v;

  fibergyro_frame_rx #(.HEADER(8'hDD), .TIMEOUT_CYC(TMO)) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .RXrd(RXrd), .RX(RX), .OEN(OEN),
    .RATE(RATE), .TEMP(TEMP), .STATUS(STATUS), .FRAME_VALID(FRAME_VALID),
    .CHK_ERR(CHK_ERR), .TMO_ERR(TMO_ERR), .FRAME_CNT(FRAME_CNT), .ERR_CNT(ERR_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (OEN === 1'b0)        oen_cnt++;
    if (FRAME_VALID === 1'b1) fv_cnt++;
    if (CHK_ERR === 1'b1)     ce_cnt++;
    if (TMO_ERR === 1'b1)     te_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a byte like the UART core: hold RXrd until OEN strobes, drop it after the latch edge.
  task automatic send_byte(input logic [7:0] b, output int lat);
    int n;
    n = 0;
    RX   = b;
    RXrd = 1'b1;
    while (OEN !== 1'b0 && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    if (OEN !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL oen_wait: observed no OEN strobe expected strobe within 20 cycles");
    end
    lat = n;
    @(posedge CLK); #1;
    RXrd = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] body, input logic [7:0] cflip);
    logic [7:0] c;
    int l;
    c = 8'h00;
    send_byte(8'hDD, hdr_lat);
    for (int i = 5; i >= 0; i--) begin
      c = c ^ body[i*8 +: 8];
      send_byte(body[i*8 +: 8], l);
    end
    send_byte(c ^ cflip, l);
  endtask

  initial begin
    int l;
    RESET = 1'b1; ENABLE = 1'b0; RXrd = 1'b0; RX = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_oen",   {31'd0, OEN}, 32'd1);
    check("rst_rate",  {8'd0, RATE}, 32'd0);
    check("rst_temp",  {16'd0, TEMP}, 32'd0);
    check("rst_stat",  {24'd0, STATUS}, 32'd0);
    check("rst_flags", {29'd0, FRAME_VALID, CHK_ERR, TMO_ERR}, 32'd0);
    check("rst_fcnt",  {16'd0, FRAME_CNT}, 32'd0);
    check("rst_ecnt",  {24'd0, ERR_CNT}, 32'd0);
    RESET = 1'b0; ENABLE = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    // Good frame; checksum 01^23^45^0A^0B^7F = 19
    oen0 = oen_cnt;
    send_frame(48'h012345_0A0B_7F, 8'h00);
    check("hdr_lat", hdr_lat, 1);
    @(posedge CLK); #1;
    check("good_fv",   {31'd0, FRAME_VALID}, 32'd1);
    check("good_rate", {8'd0, RATE}, 32'h012345);
    check("good_temp", {16'd0, TEMP}, 32'h0A0B);
    check("good_stat", {24'd0, STATUS}, 32'h7F);
    check("good_fcnt", {16'd0, FRAME_CNT}, 32'd1);
    @(posedge CLK); #1;
    check("good_fv_pulse", {31'd0, FRAME_VALID}, 32'd0);
    check("good_oen", oen_cnt - oen0, 8);
    check("good_fvcnt", fv_cnt, 1);

    // Corrupt checksum: 1C instead of 19
    send_frame(48'h012345_0A0B_7F, 8'h05);
    @(posedge CLK); #1;
    check("bad_ce",   {31'd0, CHK_ERR}, 32'd1);
    check("bad_fv",   {31'd0, FRAME_VALID}, 32'd0);
    check("bad_ecnt", {24'd0, ERR_CNT}, 32'd1);
    check("bad_rate", {8'd0, RATE}, 32'h012345);
    check("bad_stat", {24'd0, STATUS}, 32'h7F);
    check("bad_fcnt", {16'd0, FRAME_CNT}, 32'd1);
    @(posedge CLK); #1;
    check("bad_ce_pulse", {31'd0, CHK_ERR}, 32'd0);

    // Garbage then sync, with a HEADER-valued byte inside the payload; checksum 8D
    fv0 = fv_cnt; ce0 = ce_cnt;
    send_byte(8'h00, l);
    send_byte(8'h55, l);
    send_frame(48'h10DD30_4050_60, 8'h00);
    @(posedge CLK); #1;
    check("sync_rate", {8'd0, RATE}, 32'h10DD30);
    check("sync_temp", {16'd0, TEMP}, 32'h4050);
    check("sync_stat", {24'd0, STATUS}, 32'h60);
    check("sync_fcnt", {16'd0, FRAME_CNT}, 32'd2);
    check("sync_ecnt", {24'd0, ERR_CNT}, 32'd1);
    repeat (2) @(posedge CLK);
    #1;
    check("sync_fvcnt", fv_cnt - fv0, 1);
    check("sync_cecnt", ce_cnt - ce0, 0);

    // Timeout after DD 01 23
    te0 = te_cnt;
    send_byte(8'hDD, l);
    send_byte(8'h01, l);
    send_byte(8'h23, l);
    repeat (TMO + 1) @(posedge CLK);
    #1;
    check("tmo_early", {31'd0, TMO_ERR}, 32'd0);
    @(posedge CLK); #1;
    check("tmo_pulse", {31'd0, TMO_ERR}, 32'd1);
    check("tmo_ecnt",  {24'd0, ERR_CNT}, 32'd2);
    check("tmo_rate",  {8'd0, RATE}, 32'h10DD30);
    repeat (2) @(posedge CLK);
    #1;
    check("tmo_cnt", te_cnt - te0, 1);
    send_frame(48'h012345_0A0B_7F, 8'h00);
    @(posedge CLK); #1;
    check("tmo_after_fv",   {31'd0, FRAME_VALID}, 32'd1);
    check("tmo_after_rate", {8'd0, RATE}, 32'h012345);
    check("tmo_after_fcnt", {16'd0, FRAME_CNT}, 32'd3);

    // RXrd held high: OEN low every third cycle
    repeat (4) @(posedge CLK);
    #1;
    RX = 8'h00; RXrd = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK); #1;
      oen_v[i] = OEN;
    end
    RXrd = 1'b0;
    check("oen_spacing", {20'd0, oen_v}, {20'd0, 12'b110110110110});
    repeat (4) @(posedge CLK);
    #1;

    // ENABLE low: bytes drained but discarded
    ENABLE = 1'b0;
    oen0 = oen_cnt; fv0 = fv_cnt;
    send_frame(48'h0A0B0C_0D0E_0F, 8'h00);
    repeat (3) @(posedge CLK);
    #1;
    check("dis_oen",  oen_cnt - oen0, 8);
    check("dis_fv",   fv_cnt - fv0, 0);
    check("dis_fcnt", {16'd0, FRAME_CNT}, 32'd3);
    ENABLE = 1'b1;
    @(posedge CLK); #1;

    // RESET after 4 bytes, then a full frame
    send_byte(8'hDD, l);
    send_byte(8'h01, l);
    send_byte(8'h23, l);
    send_byte(8'h45, l);
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    check("mrst_oen",  {31'd0, OEN}, 32'd1);
    check("mrst_rate", {8'd0, RATE}, 32'd0);
    check("mrst_temp", {16'd0, TEMP}, 32'd0);
    check("mrst_fcnt", {16'd0, FRAME_CNT}, 32'd0);
    check("mrst_ecnt", {24'd0, ERR_CNT}, 32'd0);
    ce0 = ce_cnt;
    send_frame(48'h012345_0A0B_7F, 8'h00);
    @(posedge CLK); #1;
    check("mrst_fv",    {31'd0, FRAME_VALID}, 32'd1);
    check("mrst_rate2", {8'd0, RATE}, 32'h012345);
    check("mrst_fcnt2", {16'd0, FRAME_CNT}, 32'd1);
    check("mrst_ce",    ce_cnt - ce0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
